// File: rtl/reduce_gate_pkg.sv
// Shared types for the reduce_gate_pipe block.
// Mode encoding and the output-stage bundle.
package reduce_gate_pkg;

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_t;

  typedef struct packed {
    logic  valid;
    logic  res;
    mode_t mode;
  } s2_t;

endpackage

// File: rtl/reduce_gate_pipe_reduce_unit.sv
// Combinational reduction of a WIDTH-bit vector
// selected by mode: OR, AND, XOR or NOR.
module reduce_unit
  import reduce_gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  output logic             res
);

  always_comb begin
    res = 1'b0;
    unique case (1'b1)
      mode == MODE_OR:  res = |data;
      mode == MODE_AND: res = &data;
      mode == MODE_XOR: res = ^data;
      mode == MODE_NOR: res = ~|data;
    endcase
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// Two-stage valid/ready gate-reduction pipeline.
// Toggle counter present only with REDUCE_GATE_PIPE_CNT_EN.
module reduce_gate_pipe
  import reduce_gate_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] toggle_cnt,
  input  logic             cnt_clr
);

  logic             adv;
  logic             s1_v;
  logic [WIDTH-1:0] s1_data;
  mode_t            s1_mode;
  logic             red;
  s2_t              s2_q;

  assign adv      = !s2_q.valid | out_ready;
  assign in_ready = adv;

  // Payload only loads on a real input so idle data is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_mode <= MODE_OR;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= mode_t'(in_mode);
      end
    end
  end

  reduce_unit #(
    .WIDTH(WIDTH)
  ) u_reduce (
    .data(s1_data),
    .mode(s1_mode),
    .res (red)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '{valid: 1'b0, res: 1'b0, mode: MODE_OR};
    end else if (adv) begin
      s2_q.valid <= s1_v;
      if (s1_v) begin
        s2_q.res  <= red;
        s2_q.mode <= s1_mode;
      end
    end
  end

  assign out_valid = s2_q.valid;
  assign out_bit   = s2_q.res;
  assign out_mode  = s2_q.mode;

`ifdef REDUCE_GATE_PIPE_CNT_EN
  logic             deliver;
  logic             last_v;
  logic             last_bit;
  logic [CNT_W-1:0] cnt_q;

  assign deliver = s2_q.valid & out_ready;

  // Clear beats a same-cycle delivery and forgets the last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      last_v   <= 1'b0;
      last_bit <= 1'b0;
    end else if (cnt_clr) begin
      cnt_q    <= '0;
      last_v   <= 1'b0;
    end else if (deliver) begin
      last_v   <= 1'b1;
      last_bit <= s2_q.res;
      if (last_v && (s2_q.res != last_bit) && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign toggle_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign toggle_cnt     = '0;
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed self-checking bench for reduce_gate_pipe.
// Expects counter values according to REDUCE_GATE_PIPE_CNT_EN.
module tb_reduce_gate_pipe;

`ifdef REDUCE_GATE_PIPE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic [1:0]  out_mode;
  logic [15:0] toggle_cnt;
  logic        cnt_clr;

  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_out_bit;
  logic [1:0]  s_out_mode;
  logic [1:0]  sat_cnt;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  reduce_gate_pipe #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_mode(out_mode),
    .toggle_cnt(toggle_cnt), .cnt_clr(cnt_clr)
  );

  reduce_gate_pipe #(.WIDTH(4), .CNT_W(2)) sat_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_bit(s_out_bit), .out_mode(s_out_mode),
    .toggle_cnt(sat_cnt), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [3:0] data;
    logic [1:0] mode;
    logic       exp;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bits(input int n, input logic [7:0] bits);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = 2'b00;
      in_data  = {3'b000, bits[i]};
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_cnt();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].data = 4'(i);
      vecs[i].mode = 2'b00;
      vecs[i].exp  = (i != 0);
    end
    vecs[16] = '{4'b0110, 2'b00, 1'b1};
    vecs[17] = '{4'b0110, 2'b01, 1'b0};
    vecs[18] = '{4'b0110, 2'b10, 1'b0};
    vecs[19] = '{4'b0110, 2'b11, 1'b0};
    vecs[20] = '{4'b1111, 2'b01, 1'b1};
    vecs[21] = '{4'b1111, 2'b10, 1'b0};
    vecs[22] = '{4'b0000, 2'b11, 1'b1};
    vecs[23] = '{4'b0111, 2'b10, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'b0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_toggle", 32'(toggle_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming table, result 2 cycles after input
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2)
        chk($sformatf("vec%0d", i - 2),
            {29'd0, out_valid, out_bit, out_mode},
            {29'd0, 1'b1, vecs[i-2].exp, vecs[i-2].mode});
      if (i < NV) begin
        in_valid = 1'b1;
        in_data  = vecs[i].data;
        in_mode  = vecs[i].mode;
      end else begin
        in_valid = 1'b0;
        in_data  = 4'b1111;
      end
    end
    @(negedge clk);
    chk("drain_idle", 32'(out_valid), 32'd0);

    // Backpressure: A fills S2, B S1, C waits
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b0000;
    in_mode   = 2'b00;
    @(negedge clk);
    in_data = 4'b1111;
    in_mode = 2'b01;
    @(negedge clk);
    in_data = 4'b0000;
    in_mode = 2'b11;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold%0d", k),
          {29'd0, out_valid, out_bit, out_mode},
          {29'd0, 1'b1, 1'b0, 2'b00});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_res_b", {29'd0, out_valid, out_bit, out_mode},
        {29'd0, 1'b1, 1'b1, 2'b01});
    @(negedge clk);
    chk("bp_res_c", {29'd0, out_valid, out_bit, out_mode},
        {29'd0, 1'b1, 1'b1, 2'b11});
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Toggle counter: 0,1,1,0,1 gives 3 toggles
    clear_cnt();
    chk("cnt_cleared", 32'(toggle_cnt), 32'd0);
    send_bits(5, 8'b10110);
    chk("cnt_seq", 32'(toggle_cnt), CNT_ON ? 32'd3 : 32'd0);

    // Clear on the same cycle as a counting delivery
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b0000;
    in_mode  = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_dlv_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_wins", 32'(toggle_cnt), 32'd0);
    send_bits(1, 8'b1);
    chk("first_after_clr", 32'(toggle_cnt), 32'd0);
    send_bits(1, 8'b0);
    chk("count_resumes", 32'(toggle_cnt), CNT_ON ? 32'd1 : 32'd0);

    // Saturation on the 2-bit instance
    clear_cnt();
    send_bits(6, 8'b101010);
    chk("cnt_5tog", 32'(toggle_cnt), CNT_ON ? 32'd5 : 32'd0);
    chk("cnt_sat", 32'(sat_cnt), CNT_ON ? 32'd3 : 32'd0);

    // Reset with results in both stages
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_mode  = 2'b01;
    @(negedge clk);
    in_data = 4'b0000;
    in_mode = 2'b11;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {28'd0, out_valid, out_bit, out_mode},
        {28'd0, 1'b0, 1'b0, 2'b00});
    chk("mid_rst_toggle", 32'(toggle_cnt), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_empty%0d", k), 32'(out_valid), 32'd0);
    end

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b0111;
    in_mode  = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_lat2", {29'd0, out_valid, out_bit, out_mode},
        {29'd0, 1'b1, 1'b1, 2'b10});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
